// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: clocked exhaustive sweep of an N_IN-input gate block.
// Drives every minterm onto x, holds each for SETTLE+1 cycles, then samples
// the gate-level (a_in) and expression-level (b_in) outputs. It records the
// a_in truth table and counts the minterms where the two implementations disagree.
// Optional macro TT_EXPECT_EN adds a sticky compare of a_in against EXPECT.
module truth_table_sweeper #(
  parameter int                 N_IN   = 2,
  parameter int                 SETTLE = 1,
  parameter logic [2**N_IN-1:0] EXPECT = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      x,
  input  logic                 a_in,
  input  logic                 b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 mismatch_flag,
  output logic [N_IN-1:0]      first_bad
`ifdef TT_EXPECT_EN
  ,
  output logic                 expect_err
`endif
);

  localparam logic [3:0]      SETTLE_W = 4'(SETTLE);
  localparam logic [N_IN-1:0] X_MAX    = '1;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t              r_state, w_next;
  logic [N_IN-1:0]     r_x;
  logic [3:0]          r_hold;
  logic                r_busy, r_done;
  logic [2**N_IN-1:0]  r_tt;
  logic [N_IN:0]       r_cnt;
  logic                r_flag;
  logic [N_IN-1:0]     r_first;

  logic w_start_ok, w_sample, w_last, w_miss;

  // Start is only honoured while idle or parked in DONE; a running sweep ignores it.
  assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
  assign w_sample   = (r_state == HOLD) && (r_hold == SETTLE_W);
  assign w_last     = (r_x == X_MAX);
  assign w_miss     = (a_in != b_in);

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = HOLD;
      HOLD:    if (w_sample && w_last) w_next = DONE;
      DONE:    if (start) w_next = HOLD;
      default: w_next = IDLE;
    endcase
  end

  // State register; busy/done are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == HOLD);
      r_done  <= (w_next == DONE);
    end
  end

  // Stimulus counter, hold timer and result capture on the sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_hold  <= '0;
      r_tt    <= '0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_first <= '0;
    end else if (w_start_ok) begin
      r_x     <= '0;
      r_hold  <= '0;
      r_tt    <= '0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_first <= '0;
    end else if (w_sample) begin
      r_hold    <= '0;
      r_tt[r_x] <= a_in;
      if (w_miss) begin
        r_cnt  <= r_cnt + 1'b1;
        r_flag <= 1'b1;
        if (!r_flag) r_first <= r_x;
      end
      r_x <= w_last ? '0 : r_x + 1'b1;
    end else if (r_state == HOLD) begin
      r_hold <= r_hold + 1'b1;
    end
  end

`ifdef TT_EXPECT_EN
  logic r_exp_err;

  // Sticky flag: any sampled a_in that differs from the reference table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_exp_err <= 1'b0;
    else if (w_start_ok)                       r_exp_err <= 1'b0;
    else if (w_sample && (a_in != EXPECT[r_x])) r_exp_err <= 1'b1;
  end

  assign expect_err = r_exp_err;
`else
  // Reference table only matters when the expect check is built in.
  logic w_unused_expect;
  assign w_unused_expect = ^EXPECT;
`endif

  assign x             = r_x;
  assign busy          = r_busy;
  assign done          = r_done;
  assign tt            = r_tt;
  assign mismatch_cnt  = r_cnt;
  assign mismatch_flag = r_flag;
  assign first_bad     = r_first;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweepers (SETTLE = 0, 1, 3) share start and the
// gate-model mode controls; each gets a_in/b_in derived from its own x.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic amode = 1'b0;        // 1: a_in stuck at 0
  logic [1:0] bmode = 2'd0;  // 0: b=a, 1: b inverted at x==2, 2: b=~a

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [1:0] x0, x1, x3;
  logic a0, a1, a3, b0, b1, b3;
  logic busy0, busy1, busy3, done0, done1, done3;
  logic [3:0] tt0, tt1, tt3;
  logic [2:0] cnt0, cnt1, cnt3;
  logic flag0, flag1, flag3;
  logic [1:0] fb0, fb1, fb3;
`ifdef TT_EXPECT_EN
  logic ee0, ee1, ee3;
`endif

  function automatic logic gate_a(input logic [1:0] xv);
    return amode ? 1'b0 : (xv[1] | ~xv[0]);
  endfunction
  function automatic logic gate_b(input logic [1:0] xv, input logic av);
    case (bmode)
      2'd0:    return av;
      2'd1:    return (xv == 2'd2) ? ~av : av;
      default: return ~av;
    endcase
  endfunction

  assign a0 = gate_a(x0); assign b0 = gate_b(x0, a0);
  assign a1 = gate_a(x1); assign b1 = gate_b(x1, a1);
  assign a3 = gate_a(x3); assign b3 = gate_b(x3, a3);

  truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1101)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x0), .a_in(a0), .b_in(b0),
    .busy(busy0), .done(done0), .tt(tt0), .mismatch_cnt(cnt0),
    .mismatch_flag(flag0), .first_bad(fb0)
`ifdef TT_EXPECT_EN
    , .expect_err(ee0)
`endif
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(0), .EXPECT(4'b1101)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .tt(tt1), .mismatch_cnt(cnt1),
    .mismatch_flag(flag1), .first_bad(fb1)
`ifdef TT_EXPECT_EN
    , .expect_err(ee1)
`endif
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(3), .EXPECT(4'b1101)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x3), .a_in(a3), .b_in(b3),
    .busy(busy3), .done(done3), .tt(tt3), .mismatch_cnt(cnt3),
    .mismatch_flag(flag3), .first_bad(fb3)
`ifdef TT_EXPECT_EN
    , .expect_err(ee3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start high across exactly one rising edge (E0); returns at the negedge after E0.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_x", x0, 0);        chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);  chk("rst_tt", tt0, 0);
    chk("rst_cnt", cnt0, 0);    chk("rst_flag", flag0, 0);
    chk("rst_fb", fb0, 0);
`ifdef TT_EXPECT_EN
    chk("rst_ee", ee0, 0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Clean sweep; timing of x and done for all three SETTLE values
    pulse_start();
    for (int k = 0; k <= 16; k++) begin
      chk("s0_x",    x1,    (k < 4)  ? k     : 0);
      chk("s0_done", done1, (k >= 4) ? 1 : 0);
      chk("s1_x",    x0,    (k < 8)  ? k / 2 : 0);
      chk("s1_busy", busy0, (k < 8)  ? 1 : 0);
      chk("s1_done", done0, (k >= 8) ? 1 : 0);
      chk("s3_x",    x3,    (k < 16) ? k / 4 : 0);
      chk("s3_done", done3, (k >= 16) ? 1 : 0);
      if (k < 16) begin @(posedge clk); @(negedge clk); end
    end
    chk("clean_tt", tt0, 4'b1101);  chk("clean_cnt", cnt0, 0);
    chk("clean_flag", flag0, 0);    chk("clean_fb", fb0, 0);
    chk("clean_tt_s0", tt1, 4'b1101); chk("clean_tt_s3", tt3, 4'b1101);

    // Single mismatch at minterm 2
    bmode = 2'd1;
    pulse_start();
    wait_edges(16);
    chk("m1_tt", tt0, 4'b1101);   chk("m1_cnt", cnt0, 1);
    chk("m1_flag", flag0, 1);     chk("m1_fb", fb0, 2);
    chk("m1_cnt_s0", cnt1, 1);    chk("m1_fb_s0", fb1, 2);
    chk("m1_cnt_s3", cnt3, 1);    chk("m1_fb_s3", fb3, 2);

    // Full mismatch: counter must reach 4 without wrapping; results clear on start
    bmode = 2'd2;
    pulse_start();
    chk("m4_clr_cnt", cnt0, 0);   chk("m4_clr_flag", flag0, 0);
    chk("m4_clr_tt", tt0, 0);     chk("m4_clr_fb", fb0, 0);
    wait_edges(16);
    chk("m4_tt", tt0, 4'b1101);   chk("m4_cnt", cnt0, 4);
    chk("m4_flag", flag0, 1);     chk("m4_fb", fb0, 0);
    chk("m4_cnt_s0", cnt1, 4);    chk("m4_cnt_s3", cnt3, 4);

    // Start pulsed mid-sweep is ignored
    bmode = 2'd0;
    pulse_start();
    wait_edges(2);
    chk("ign_x", x0, 1);
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
    wait_edges(5);
    chk("ign_done", done0, 1);    chk("ign_busy", busy0, 0);
    chk("ign_tt", tt0, 4'b1101);  chk("ign_cnt", cnt0, 0);
    chk("ign_x_end", x0, 0);      chk("ign_s3_x", x3, 2);

    // Asynchronous reset mid-sweep
    pulse_start();
    wait_edges(4);
    chk("ar_x_pre", x0, 2);
    rst_n = 1'b0;
    #1;
    chk("ar_x", x0, 0);      chk("ar_busy", busy0, 0);
    chk("ar_done", done1, 0); chk("ar_tt", tt0, 0);
    chk("ar_tt_s3", tt3, 0);
    wait_edges(1);
    chk("ar_hold_busy", busy0, 0);
    rst_n = 1'b1;
    pulse_start();
    chk("ar_new_x", x0, 0);  chk("ar_new_busy", busy0, 1);
    wait_edges(8);
    chk("ar_new_done", done0, 1); chk("ar_new_tt", tt0, 4'b1101);
    wait_edges(8);
    chk("ar_new_done_s3", done3, 1);

`ifdef TT_EXPECT_EN
    // Expect check: stuck-at-0 gate against EXPECT=1101
    amode = 1'b1;
    pulse_start();
    chk("ee_e0", ee0, 0);
    wait_edges(1);
    chk("ee_e1", ee0, 0);
    wait_edges(1);
    chk("ee_e2", ee0, 1);
    wait_edges(14);
    chk("ee_sticky", ee0, 1);
    amode = 1'b0;
    pulse_start();
    chk("ee_clr", ee0, 0);
    wait_edges(16);
    chk("ee_good", ee0, 0);   chk("ee_good_s3", ee3, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
